// File: rtl/store_buffer_pkg.sv
// Shared types and constants for the store buffer.
// FSM encoding, default depth and a byte-lane mask helper.
package store_buffer_pkg;

  localparam int SB_DEPTH = 4;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRAIN = 2'd1,
    S_LOAD  = 2'd2
  } sb_state_t;

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    for (int b = 0; b < 4; b++) begin
      lane_mask[8*b +: 8] = {8{be[b]}};
    end
  endfunction

endpackage

// File: rtl/sb_fwd_merge.sv
// Store-to-load forwarding merge: walks valid entries oldest to
// youngest and overlays matching bytes lane by lane.
module sb_fwd_merge
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic [29:0]             addr,
  input  logic [DEPTH-1:0][29:0]  ent_addr,
  input  logic [DEPTH-1:0][31:0]  ent_data,
  input  logic [DEPTH-1:0][3:0]   ent_be,
  input  logic [PW-1:0]           head,
  input  logic [PW:0]             count,
  output logic [31:0]             data,
  output logic [3:0]              mask
);

  always_comb begin : merge
    logic [PW-1:0] idx;
    data = '0;
    mask = '0;
    idx  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if ((PW+1)'(i) < count && ent_addr[idx] == addr) begin
        for (int b = 0; b < 4; b++) begin
          if (ent_be[idx][b]) begin
            data[8*b +: 8] = ent_data[idx][8*b +: 8];
            mask[b]        = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Write-back store buffer between the M stage and memory with
// byte-merging load forwarding and a drain/load memory FSM.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_byteen,
  input  logic        cpu_we,
  input  logic        cpu_re,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byteen,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  sb_state_t state;

  logic [DEPTH-1:0][29:0] ent_addr;
  logic [DEPTH-1:0][31:0] ent_data;
  logic [DEPTH-1:0][3:0]  ent_be;
  logic [PW-1:0]          head;
  logic [PW-1:0]          tail;
  logic [PW:0]            count;

  logic [31:0] fwd_data;
  logic [3:0]  fwd_mask;
  logic [3:0]  cov;
  logic        hit;
  logic        miss;
  logic        pop;
  logic        push;
  logic [31:0] rdata_c;
  logic        stall_c;
  logic        unused_lo;

  assign unused_lo = ^cpu_addr[1:0];

  sb_fwd_merge #(.DEPTH(DEPTH)) u_merge (
    .addr     (cpu_addr[31:2]),
    .ent_addr (ent_addr),
    .ent_data (ent_data),
    .ent_be   (ent_be),
    .head     (head),
    .count    (count),
    .data     (fwd_data),
    .mask     (fwd_mask)
  );

  assign cov  = fwd_mask & cpu_byteen;
  assign hit  = (cov == cpu_byteen);
  assign miss = !hit && (cov == 4'd0);
  assign pop  = (state == S_DRAIN) && mem_ack;
  assign push = cpu_we && ((count < FULL) || pop);

  always_comb begin
    rdata_c = '0;
    stall_c = 1'b0;
    if (cpu_re) begin
      if (state == S_LOAD) begin
        stall_c = !mem_ack;
        rdata_c = mem_ack ? mem_rdata : '0;
      end else if (hit) begin
        rdata_c = fwd_data & lane_mask(cpu_byteen);
      end else begin
        stall_c = 1'b1;
      end
    end else if (cpu_we) begin
      stall_c = !push;
    end
  end

  // Outputs are forced quiet while reset is held.
  assign cpu_stall = reset & stall_c;
  assign cpu_rdata = reset ? rdata_c : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr[tail] <= cpu_addr[31:2];
      ent_data[tail] <= cpu_wdata;
      ent_be[tail]   <= cpu_byteen;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(pop);
      tail  <= tail + PW'(push);
      count <= count + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_byteen <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cpu_re && miss) begin
            state      <= S_LOAD;
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= {cpu_addr[31:2], 2'b00};
            mem_wdata  <= '0;
            mem_byteen <= cpu_byteen;
          end else if (count != '0) begin
            state      <= S_DRAIN;
            mem_req    <= 1'b1;
            mem_we     <= 1'b1;
            mem_addr   <= {ent_addr[head], 2'b00};
            mem_wdata  <= ent_data[head];
            mem_byteen <= ent_be[head];
          end
        end
        S_DRAIN: begin
          // A miss cannot turn into a hit by popping, so go straight to LOAD.
          if (mem_ack && cpu_re && miss) begin
            state      <= S_LOAD;
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= {cpu_addr[31:2], 2'b00};
            mem_wdata  <= '0;
            mem_byteen <= cpu_byteen;
          end else if (mem_ack) begin
            state   <= S_IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end
        end
        S_LOAD: begin
          if (mem_ack) begin
            state   <= S_IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
          end
        end
        default: begin
          state   <= S_IDLE;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer (DEPTH = 4).
// Inputs change 1ns after the rising edge; outputs sampled on the falling edge.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [3:0]  cpu_byteen;
  logic        cpu_we;
  logic        cpu_re;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byteen;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_byteen (cpu_byteen),
    .cpu_we     (cpu_we),
    .cpu_re     (cpu_re),
    .cpu_rdata  (cpu_rdata),
    .cpu_stall  (cpu_stall),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_byteen (mem_byteen),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic put(input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] be);
    cpu_we = 1'b1; cpu_re = 1'b0;
    cpu_addr = a; cpu_wdata = d; cpu_byteen = be;
  endtask

  task automatic get(input logic [31:0] a, input logic [3:0] be);
    cpu_we = 1'b0; cpu_re = 1'b1;
    cpu_addr = a; cpu_wdata = '0; cpu_byteen = be;
  endtask

  task automatic none();
    cpu_we = 1'b0; cpu_re = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; cpu_byteen = '0;
  endtask

  // Wait (bounded) for a drain write, check its address, ack it once.
  task automatic ack_one(input string tag, input logic [31:0] a);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      smp();
      if (mem_req && mem_we) begin
        found = 1'b1;
        chk({tag, "_addr"}, mem_addr, a);
        mem_ack = 1'b1;
        nxt();
        mem_ack = 1'b0;
      end
    end
    chk({tag, "_seen"}, 32'(found), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    none();
    repeat (2) @(posedge clk);
    smp();
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_stall", 32'(cpu_stall), 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_be", 32'(mem_byteen), 32'd0);
    nxt();
    reset = 1'b1;

    // Full forward of a single buffered store.
    put(32'h100, 32'h11223344, 4'hF);
    smp(); chk("a_st_stall", 32'(cpu_stall), 32'd0);
    nxt();
    get(32'h100, 4'hF);
    smp();
    chk("a_fwd_rdata", cpu_rdata, 32'h11223344);
    chk("a_fwd_stall", 32'(cpu_stall), 32'd0);
    chk("a_fwd_noreq", 32'(mem_req), 32'd0);
    nxt();
    none();
    smp();
    chk("a_drain_we", 32'({mem_req, mem_we}), 32'd3);
    chk("a_drain_data", mem_wdata, 32'h11223344);
    mem_ack = 1'b1;
    nxt();
    mem_ack = 1'b0;
    smp(); chk("a_idle", 32'(mem_req), 32'd0);
    nxt();

    // Fill to DEPTH, fifth store stalls until a pop frees a slot.
    for (int i = 0; i < 4; i++) begin
      put(32'h10 + 32'(4*i), 32'(i + 1), 4'hF);
      smp(); chk("b_fill_stall", 32'(cpu_stall), 32'd0);
      nxt();
    end
    put(32'h20, 32'd5, 4'hF);
    smp(); chk("b_full_stall", 32'(cpu_stall), 32'd1);
    nxt();
    smp();
    chk("b_full_stall2", 32'(cpu_stall), 32'd1);
    chk("b_head_addr", mem_addr, 32'h10);
    mem_ack = 1'b1;
    #1 chk("b_pop_push", 32'(cpu_stall), 32'd0);
    nxt();
    mem_ack = 1'b0;
    put(32'h24, 32'd6, 4'hF);
    smp(); chk("b_still_full", 32'(cpu_stall), 32'd1);
    nxt();
    none();
    ack_one("b_d1", 32'h14);
    ack_one("b_d2", 32'h18);
    ack_one("b_d3", 32'h1C);
    ack_one("b_d4", 32'h20);

    // Byte merge across two stores, including the entry being popped.
    put(32'h300, 32'hAAAAAAAA, 4'hF);
    nxt();
    put(32'h300, 32'h000000BB, 4'h1);
    nxt();
    get(32'h300, 4'hF);
    smp();
    chk("c_merge", cpu_rdata, 32'hAAAAAABB);
    chk("c_merge_stall", 32'(cpu_stall), 32'd0);
    nxt();
    mem_ack = 1'b1;
    smp(); chk("c_prepop", cpu_rdata, 32'hAAAAAABB);
    nxt();
    mem_ack = 1'b0;
    smp(); chk("c_partial", 32'(cpu_stall), 32'd1);
    nxt();
    smp();
    chk("c_drain_be", 32'(mem_byteen), 32'h1);
    mem_ack = 1'b1;
    nxt();
    mem_ack = 1'b0;
    smp(); chk("c_miss_stall", 32'(cpu_stall), 32'd1);
    nxt();
    smp();
    chk("c_load_we", 32'({mem_req, mem_we}), 32'd2);
    mem_rdata = 32'hAAAAAABB;
    mem_ack = 1'b1;
    #1 chk("c_load_rdata", cpu_rdata, 32'hAAAAAABB);
    nxt();
    mem_ack = 1'b0;
    none();

    // Partial hit waits for drain, then reads memory.
    put(32'h200, 32'h00005566, 4'h3);
    nxt();
    get(32'h200, 4'hF);
    smp(); chk("d_partial", 32'(cpu_stall), 32'd1);
    nxt();
    smp();
    chk("d_drain", 32'({mem_req, mem_we}), 32'd3);
    chk("d_drain_addr", mem_addr, 32'h200);
    mem_ack = 1'b1;
    #1 chk("d_ack_stall", 32'(cpu_stall), 32'd1);
    nxt();
    mem_ack = 1'b0;
    smp();
    chk("d_reeval_stall", 32'(cpu_stall), 32'd1);
    chk("d_gap", 32'(mem_req), 32'd0);
    nxt();
    smp();
    chk("d_load", 32'({mem_req, mem_we}), 32'd2);
    chk("d_load_addr", mem_addr, 32'h200);
    chk("d_load_be", 32'(mem_byteen), 32'hF);
    mem_rdata = 32'hCAFEF00D;
    mem_ack = 1'b1;
    #1;
    chk("d_done_stall", 32'(cpu_stall), 32'd0);
    chk("d_rdata", cpu_rdata, 32'hCAFEF00D);
    nxt();
    mem_ack = 1'b0;
    none();

    // Miss load overtakes pending stores; ack arrives late.
    put(32'h500, 32'h5, 4'hF);
    nxt();
    put(32'h504, 32'h6, 4'hF);
    nxt();
    put(32'h508, 32'h7, 4'hF);
    nxt();
    get(32'h400, 4'hF);
    smp();
    chk("e_stall", 32'(cpu_stall), 32'd1);
    chk("e_drain_kept", mem_addr, 32'h500);
    nxt();
    mem_ack = 1'b1;
    smp(); chk("e_ack_stall", 32'(cpu_stall), 32'd1);
    nxt();
    mem_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      smp();
      chk("e_load_first", 32'({mem_req, mem_we}), 32'd2);
      chk("e_wait_stall", 32'(cpu_stall), 32'd1);
      chk("e_load_addr", mem_addr, 32'h400);
      nxt();
    end
    mem_rdata = 32'h12345678;
    mem_ack = 1'b1;
    smp();
    chk("e_done_stall", 32'(cpu_stall), 32'd0);
    chk("e_rdata", cpu_rdata, 32'h12345678);
    nxt();
    mem_ack = 1'b0;
    none();
    ack_one("e_d1", 32'h504);
    ack_one("e_d2", 32'h508);

    // Reset in the middle of a drain drops everything.
    put(32'h600, 32'h1, 4'hF);
    nxt();
    put(32'h604, 32'h2, 4'hF);
    nxt();
    put(32'h608, 32'h3, 4'hF);
    nxt();
    none();
    smp();
    chk("f_draining", 32'({mem_req, mem_we}), 32'd3);
    reset = 1'b0;
    #1;
    chk("f_rst_req", 32'(mem_req), 32'd0);
    chk("f_rst_stall", 32'(cpu_stall), 32'd0);
    nxt();
    reset = 1'b1;
    get(32'h600, 4'hF);
    smp(); chk("f_miss_stall", 32'(cpu_stall), 32'd1);
    nxt();
    smp();
    chk("f_mem_read", 32'({mem_req, mem_we}), 32'd2);
    chk("f_read_addr", mem_addr, 32'h600);
    mem_rdata = 32'h0BADF00D;
    mem_ack = 1'b1;
    #1 chk("f_rdata", cpu_rdata, 32'h0BADF00D);
    nxt();
    mem_ack = 1'b0;
    none();
    nxt();
    smp(); chk("f_empty", 32'(mem_req), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter: DEPTH, default 4, number of buffered store entries (power of two, 2..16).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 cpu_addr  input  32  M-stage byte address; bits [1:0] ignored, entries matched on [31:2].
REQ-005 cpu_wdata  input  32  store data, already lane-aligned.
REQ-006 cpu_byteen  input  4  byte lanes of store or load.
REQ-007 cpu_we / cpu_re  input  1 each  store / load request; both high is illegal.
REQ-008 cpu_rdata  output  32  load result, valid in the cycle cpu_re is high and cpu_stall is low.
REQ-009 cpu_stall  output  1  freeze M stage and upstream; request held unchanged while high.
REQ-010 mem_req  output  1  memory transaction valid.
REQ-011 mem_we  output  1  1 = write (drain), 0 = read (load).
REQ-012 mem_addr / mem_wdata / mem_byteen  output  32/32/4  transaction payload; stable while mem_req high and mem_ack low.
REQ-013 mem_ack  input  1  transaction completes in this cycle; mem_rdata valid with ack on reads.
REQ-014 mem_rdata  input  32  read data.

Function
REQ-015 Buffer: FIFO of DEPTH entries {word addr, data, byteen}; head/tail pointers wrap modulo DEPTH; count 0..DEPTH.
REQ-016 Store: accepted (enqueued at tail) when cpu_we and (count<DEPTH or drain pop this cycle); otherwise cpu_stall=1.
REQ-017 Full + simultaneous pop: store accepted, count unchanged, no stall.
REQ-018 Load forwarding: for all valid entries with matching word address, merge bytes oldest->youngest per lane; if merged byteen covers cpu_byteen, cpu_rdata = merged bytes (other lanes 0), cpu_stall=0, zero latency, no memory access.
REQ-019 Partial hit (some but not all requested lanes covered): cpu_stall=1 until buffer drains the matching entries, then load re-evaluated.
REQ-020 Miss: load issued to memory; cpu_stall=1 until cycle of mem_ack, where cpu_rdata = mem_rdata and cpu_stall=0.
REQ-021 FSM states IDLE, DRAIN, LOAD. IDLE: miss load -> LOAD (priority), else count>0 -> DRAIN. DRAIN: mem_req=1, mem_we=1, head payload; on ack pop, -> IDLE. LOAD: mem_req=1, mem_we=0; on ack -> IDLE.
REQ-022 A DRAIN in flight is never aborted; a load arriving mid-drain waits (stalled) until ack, then enters LOAD next cycle.
REQ-023 Forwarding check includes an entry being popped in the same cycle (pre-pop contents).
REQ-024 Stores enqueued during LOAD are permitted if space exists.
REQ-025 mem_req deasserts for at least zero cycles between transactions (back-to-back allowed).

Reset
REQ-026 On reset low: state IDLE, count=0, pointers 0, mem_req=0, mem_we=0, cpu_stall=0, cpu_rdata=0, mem_addr/wdata/byteen=0; entries need not clear.
REQ-027 Reset mid-transaction abandons it; buffered stores are discarded.

Structure
REQ-028 Shared package holds FSM state encoding (2 bits) and DEPTH default constant.
REQ-029 One sub-module sb_fwd_merge: combinational per-lane merge of entries, outputs merged data and coverage mask.

Verification
REQ-030 Store 0x11223344 be=1111 @0x100, mem_ack tied 0, load @0x100 be=1111 -> rdata 0x11223344, stall 0, no mem read.
REQ-031 DEPTH=4: five back-to-back stores, mem_ack=0 -> 5th stalls; ack once -> 5th accepted same cycle, count=4.
REQ-032 Store be=0011 @0x200, load be=1111 @0x200 -> stall until drain ack, then memory read issued, rdata = mem_rdata.
REQ-033 Stores 0xAAAAAAAA be=1111 then 0x000000BB be=0001 @0x300, load be=1111 -> rdata 0xAAAAAABB.
REQ-034 Miss load @0x400 with 2 stores pending, mem_ack 3 cycles late -> LOAD before DRAIN, stall exactly until ack, rdata correct.
REQ-035 Assert reset during DRAIN with 3 entries -> mem_req 0 immediately, count 0, first post-reset load to that address goes to memory.
